// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder for the 16-bit core.
// Handles word stores, word loads and byte loads (zero or sign extended).
// The backing array has a fixed access latency. mem_stall holds the
// pipeline until the access completes.
// Optional build macro: DMEM_MISALIGN_CHECK_EN. When it is defined, a word
// access with addr[0] = 1 is rejected and flagged on misalign_err.
module dmem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic              ByteAcc,
    input  logic              SignExtendMemData,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              mem_stall,
    output logic              misalign_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic              op_rd_q, op_rd_d;
    logic              op_wr_q, op_wr_d;
    logic              byte_q, byte_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              cur_rd, cur_wr, cur_byte, cur_sext;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] cur_word;
    logic [7:0]        cur_lane;
    logic              cur_bad;
    logic              stall_c;
    logic              enter_done;
    logic              mem_we;
    logic              unused_addr_bits;

    // In the accept cycle the operation comes straight from the inputs;
    // after that it comes from the copy latched at accept.
    always_comb begin
        if (state_q == IDLE) begin
            cur_rd    = MemRd;
            cur_wr    = MemWr;
            cur_byte  = ByteAcc;
            cur_sext  = SignExtendMemData;
            cur_addr  = addr;
            cur_wdata = wdata;
        end else begin
            cur_rd    = op_rd_q;
            cur_wr    = op_wr_q;
            cur_byte  = byte_q;
            cur_sext  = sext_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Index drops addr[0] and the upper address bits, so word accesses are
    // forced aligned and out-of-range addresses wrap.
    assign cur_idx          = cur_addr[IDX_W:1];
    assign cur_word         = mem[cur_idx];
    assign cur_lane         = cur_addr[0] ? cur_word[15:8] : cur_word[7:0];
    assign unused_addr_bits = ^cur_addr[ADDR_W-1:IDX_W+1];

`ifdef DMEM_MISALIGN_CHECK_EN
    // A store is always a word access. A load is a word access unless ByteAcc is set.
    assign cur_bad = (cur_wr | ~cur_byte) & cur_addr[0];
`else
    assign cur_bad = 1'b0;
`endif

    // Next state, the latency counter, and the result that is captured on
    // the edge into DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        op_rd_d    = op_rd_q;
        op_wr_d    = op_wr_q;
        byte_d     = byte_q;
        sext_d     = sext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        stall_c    = 1'b0;
        enter_done = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemRd || MemWr) begin
                    op_rd_d = MemRd;
                    op_wr_d = MemWr;
                    byte_d  = ByteAcc;
                    sext_d  = SignExtendMemData;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    stall_c = 1'b1;
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                    end else begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                // Request inputs still belong to this instruction; ignore them.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_done) begin
            // If MemRd and MemWr are both set, the access is a write and is flagged.
            err_d = (cur_rd & cur_wr) | cur_bad;
            if (cur_wr) begin
                mem_we = ~cur_bad & reset;
            end else begin
                rvalid_d = 1'b1;
                if (cur_bad) begin
                    rdata_d = '0;
                end else if (cur_byte) begin
                    rdata_d = {{(DATA_W-8){cur_sext & cur_lane[7]}}, cur_lane};
                end else begin
                    rdata_d = cur_word;
                end
            end
        end
    end

    // Control state and output registers. A synchronous reset aborts any
    // access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            op_rd_q  <= 1'b0;
            op_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            op_rd_q  <= op_rd_d;
            op_wr_q  <= op_wr_d;
        end
    end

    // Request operands latched at accept. This is data only, so it has no reset.
    always_ff @(posedge clk) begin
        byte_q  <= byte_d;
        sext_q  <= sext_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Array write commits on the edge into DONE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    // While reset is held, no stall is raised, even if a request is present.
    assign mem_stall    = stall_c & reset;
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed steps followed by random accesses,
// checked against a word-array reference model.
module tb_dmem_responder;

    localparam int LAT = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRd, MemWr, ByteAcc, SignExtendMemData;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        rvalid, mem_stall, misalign_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [256];
    logic [15:0] last_rdata;

    dmem_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(256), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
        .ByteAcc(ByteAcc), .SignExtendMemData(SignExtendMemData),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .mem_stall(mem_stall), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model for one access, written in terms of plain arithmetic.
    task automatic model(input bit rd, input bit wr, input bit bt, input bit sx,
                         input int a, input logic [15:0] wd,
                         output bit exp_v, output logic [15:0] exp_d, output bit exp_e);
        int idx;
        int b;
        bit word_acc;
        bit bad;
        idx      = (a / 2) % 256;
        word_acc = wr || !bt;
        bad      = MIS_EN && word_acc && (a % 2 == 1);
        exp_e    = (rd && wr) || bad;
        if (wr) begin
            exp_v = 1'b0;
            if (!bad) mem_m[idx] = wd;
        end else begin
            exp_v = 1'b1;
            if (bad) begin
                last_rdata = 16'h0000;
            end else if (bt) begin
                b = (a % 2 == 1) ? int'(mem_m[idx]) / 256 : int'(mem_m[idx]) % 256;
                last_rdata = (sx && b >= 128) ? 16'(b + 16'hFF00) : 16'(b);
            end else begin
                last_rdata = mem_m[idx];
            end
        end
        exp_d = last_rdata;
    endtask

    // Drives one access and checks every cycle until the DONE cycle. It is
    // called just after a rising edge. The request stays asserted through DONE.
    task automatic access(input bit rd, input bit wr, input bit bt, input bit sx,
                          input logic [15:0] a, input logic [15:0] wd);
        bit          exp_v, exp_e;
        logic [15:0] exp_d;
        model(rd, wr, bt, sx, int'(a), wd, exp_v, exp_d, exp_e);
        MemRd = rd; MemWr = wr; ByteAcc = bt; SignExtendMemData = sx;
        addr = a; wdata = wd;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("stall_busy", 16'(mem_stall), 16'd1);
            check("rvalid_busy", 16'(rvalid), 16'd0);
            check("err_busy", 16'(misalign_err), 16'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_done", 16'(mem_stall), 16'd0);
        check("rvalid_done", 16'(rvalid), 16'(exp_v));
        check("rdata_done", rdata, exp_d);
        check("err_done", 16'(misalign_err), 16'(exp_e));
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        MemRd = 1'b0; MemWr = 1'b0;
        @(negedge clk);
        check("stall_idle", 16'(mem_stall), 16'd0);
        check("rvalid_idle", 16'(rvalid), 16'd0);
        check("rdata_hold", rdata, last_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; MemRd = 1'b1; MemWr = 1'b0; ByteAcc = 1'b0;
        SignExtendMemData = 1'b0; addr = 16'h0010; wdata = 16'h0000;
        last_rdata = 16'h0000;

        // Reset held for two cycles while a read request is present.
        repeat (2) begin
            @(negedge clk);
            check("rst_stall", 16'(mem_stall), 16'd0);
            check("rst_rvalid", 16'(rvalid), 16'd0);
            check("rst_rdata", rdata, 16'h0000);
            check("rst_err", 16'(misalign_err), 16'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // Word store followed by word load.
        access(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
        access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        // Byte loads from the stored word.
        access(1'b1, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000);
        check("lbs_hi_value", last_rdata, 16'hFFBE);
        access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
        check("lbu_hi_value", last_rdata, 16'h00BE);
        access(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
        check("lbs_lo_value", last_rdata, 16'hFFEF);
        // Back-to-back: a read held through DONE, then a write in the next cycle.
        access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h5555);
        idle_cycle();

        // Reset asserted in the accept cycle: the write must not be accepted.
        MemWr = 1'b1; addr = 16'h0020; wdata = 16'h1234; reset = 1'b0;
        @(negedge clk);
        check("rst_acc_stall", 16'(mem_stall), 16'd0);
        @(posedge clk); #1;
        reset = 1'b1; MemWr = 1'b0; last_rdata = 16'h0000;
        idle_cycle();
        // Reset asserted in the BUSY cycle, before the commit edge.
        MemWr = 1'b1; addr = 16'h0020; wdata = 16'h4321;
        @(negedge clk);
        check("rst_busy_acc", 16'(mem_stall), 16'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy_stall", 16'(mem_stall), 16'd0);
        @(posedge clk); #1;
        reset = 1'b1; MemWr = 1'b0; last_rdata = 16'h0000;
        idle_cycle();
        access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
        check("rst_no_commit", last_rdata, 16'h5555);

        // Misaligned word read.
        access(1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'hA5C3);
        access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
        // Read and write requested together; the access is treated as a write and flagged.
        access(1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h7E81);
        access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        // Index wraps: address 0x0210 aliases word 0x0010.
        access(1'b0, 1'b1, 1'b0, 1'b0, 16'h0210, 16'hC0DE);
        access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);

        // Fill words 0..31, then run random accesses over that range.
        for (int w = 0; w < 32; w++) begin
            access(1'b0, 1'b1, 1'b0, 1'b0, 16'(w * 2), 16'($urandom));
        end
        for (int n = 0; n < 80; n++) begin
            bit          rd, wr, bt, sx;
            logic [15:0] a;
            int          op;
            op = int'($urandom_range(0, 9));
            rd = (op < 6) || (op == 9);
            wr = (op >= 6);
            bt = 1'($urandom);
            sx = 1'($urandom);
            a  = {7'($urandom), 3'b000, 5'($urandom), 1'($urandom)};
            access(rd, wr, bt, sx, a, 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
